// File: rtl/spi_tx_feeder.sv
// spi_tx_feeder: byte FIFO in front of an SPI master. Launches one byte
// per start pulse, waits for done, then holds an inter-byte gap.
// Ports:
//   clock, reset         system clock, async active-high reset
//   wr_en, wr_data       control-side byte push
//   spi_ready, spi_done  master idle / transfer-finished pulse
//   spi_start            one-cycle launch pulse to the master
//   spi_tx_data          byte held stable for the master
//   full, empty, level   registered FIFO occupancy
//   busy                 launcher not idle
//   overflow             sticky, push dropped while full
//   timeout_err          sticky, master never answered
// Option: define SPI_TX_FEEDER_TIMEOUT_EN to bound WAIT_DONE to
// TIMEOUT_CYCLES clocks; otherwise timeout_err is tied low.

module spi_tx_feeder #(
  parameter int DEPTH          = 8,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          spi_ready,
  input  logic          spi_done,
  output logic          spi_start,
  output logic [7:0]    spi_tx_data,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level,
  output logic          busy,
  output logic          overflow,
  output logic          timeout_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT_DONE,
    GAP
  } state_t;

  state_t state;
  state_t nxt;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [LW-1:0] cnt;
  logic [GW-1:0] gcnt;
  logic          push;
  logic          pop;
  logic          expire;
  logic          gap_end;

  assign full  = (cnt == LW'(DEPTH));
  assign empty = (cnt == '0);
  assign level = cnt;
  assign busy  = (state != IDLE);

  assign spi_start = (state == START);

  assign pop  = (state == IDLE) && !empty && spi_ready;
  // A pop in the same cycle frees a slot, so a push while full is
  // still taken then.
  assign push = wr_en && (!full || pop);

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wptr] <= wr_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr     <= '0;
      rptr     <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wptr <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
      if (push && !pop) begin
        cnt <= cnt + 1'b1;
      end else if (pop && !push) begin
        cnt <= cnt - 1'b1;
      end
      if (wr_en && !push) begin
        overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      spi_tx_data <= 8'h00;
    end else if (pop) begin
      spi_tx_data <= mem[rptr];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      gcnt <= '0;
    end else if (state == GAP) begin
      gcnt <= gcnt + 1'b1;
    end else begin
      gcnt <= '0;
    end
  end

  assign gap_end = (gcnt == GW'(GAP_CYCLES - 1));

`ifdef SPI_TX_FEEDER_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ?
    $clog2(TIMEOUT_CYCLES) : 1;

  logic [TW-1:0] tcnt;

  // Counter is zero on the first WAIT_DONE cycle, so expiry lands
  // exactly TIMEOUT_CYCLES clocks after entry.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tcnt <= '0;
    end else if (state == WAIT_DONE) begin
      tcnt <= tcnt + 1'b1;
    end else begin
      tcnt <= '0;
    end
  end

  assign expire = (state == WAIT_DONE) && !spi_done &&
                  (tcnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      timeout_err <= 1'b0;
    end else if (expire) begin
      timeout_err <= 1'b1;
    end
  end
`else
  assign expire      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (pop) begin
          nxt = START;
        end
      end
      START: begin
        nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (spi_done || expire) begin
          if (GAP_CYCLES == 0) begin
            nxt = IDLE;
          end else begin
            nxt = GAP;
          end
        end
      end
      GAP: begin
        if (gap_end) begin
          nxt = IDLE;
        end
      end
      default: begin
        nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_spi_tx_feeder.sv
// tb_spi_tx_feeder: scoreboard bench for spi_tx_feeder with a simple
// SPI master model answering each start with a delayed done pulse.

module tb_spi_tx_feeder;

  localparam int GAP = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       spi_ready = 1'b0;
  logic       spi_done;
  logic       spi_start;
  logic [7:0] spi_tx_data;
  logic       full;
  logic       empty;
  logic [3:0] level;
  logic       busy;
  logic       overflow;
  logic       timeout_err;

  spi_tx_feeder #(
    .DEPTH(8),
    .GAP_CYCLES(GAP),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clock(clock),
    .reset(reset),
    .wr_en(wr_en),
    .wr_data(wr_data),
    .spi_ready(spi_ready),
    .spi_done(spi_done),
    .spi_start(spi_start),
    .spi_tx_data(spi_tx_data),
    .full(full),
    .empty(empty),
    .level(level),
    .busy(busy),
    .overflow(overflow),
    .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int         n_start = 0;
  logic [7:0] obs_data [256];
  int         obs_t [256];
  bit         prev_start = 1'b0;
  bit         dbl = 1'b0;

  always @(negedge clock) begin
    prev_start <= spi_start;
    if (!reset && spi_start) begin
      obs_data[n_start % 256] <= spi_tx_data;
      obs_t[n_start % 256]    <= cyc;
      n_start                 <= n_start + 1;
      if (prev_start) dbl <= 1'b1;
    end
  end

  bit auto_done = 1'b0;
  int done_dly = 2;

  initial begin
    spi_done = 1'b0;
    forever begin
      @(negedge clock);
      if (auto_done && spi_start && !reset) begin
        repeat (done_dly) @(posedge clock);
        #1 spi_done = 1'b1;
        @(posedge clock);
        #1 spi_done = 1'b0;
      end
    end
  end

  int         errors = 0;
  int         checks = 0;
  logic [7:0] sb [$];
  int         rd_idx = 0;

  task automatic push(input logic [7:0] b, input bit acc);
    @(posedge clock);
    #1;
    wr_en   = 1'b1;
    wr_data = b;
    if (acc) sb.push_back(b);
  endtask

  task automatic wr_stop();
    @(posedge clock);
    #1 wr_en = 1'b0;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    wr_en     = 1'b0;
    spi_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    sb.delete();
    rd_idx = n_start;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if (level !== 4'd0 || empty !== 1'b1 || full !== 1'b0) begin
      errors++;
      $display("FAIL reset_fifo level=%0d empty=%b full=%b exp 0/1/0",
               level, empty, full);
    end
    checks++;
    if (busy !== 1'b0 || spi_start !== 1'b0 || spi_tx_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_fsm busy=%b start=%b data=%h exp 0/0/00",
               busy, spi_start, spi_tx_data);
    end
    checks++;
    if (overflow !== 1'b0 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags ovf=%b tmo=%b exp 0/0",
               overflow, timeout_err);
    end
    do_reset();
  endtask

  task automatic test_latency();
    int k;
    logic [7:0] exp;
    do_reset();
    spi_ready = 1'b1;
    auto_done = 1'b1;
    done_dly  = 20;
    push(8'hA5, 1'b1);
    wr_stop();
    @(negedge clock);
    checks++;
    if (level !== 4'd1 || spi_start !== 1'b0) begin
      errors++;
      $display("FAIL lat_level level=%0d start=%b exp 1/0",
               level, spi_start);
    end
    @(negedge clock);
    checks++;
    if (spi_start !== 1'b1 || spi_tx_data !== 8'hA5) begin
      errors++;
      $display("FAIL lat_start start=%b data=%h exp 1/a5",
               spi_start, spi_tx_data);
    end
    @(negedge clock);
    checks++;
    if (spi_start !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL lat_pulse start=%b busy=%b exp 0/1",
               spi_start, busy);
    end
    k = 0;
    while (!spi_done && k < 100) begin
      @(negedge clock);
      k++;
    end
    checks++;
    if (!spi_done || cyc - obs_t[rd_idx % 256] != 20) begin
      errors++;
      $display("FAIL lat_done seen=%b dist=%0d exp 1/20",
               spi_done, cyc - obs_t[rd_idx % 256]);
    end
    k = 0;
    do begin
      @(negedge clock);
      k++;
    end while (busy && k < 50);
    checks++;
    if (k != GAP + 1) begin
      errors++;
      $display("FAIL busy_fall cycles=%0d exp=%0d", k, GAP + 1);
    end
    while (rd_idx < n_start) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL lat_extra got=%h exp none", obs_data[rd_idx % 256]);
      end else begin
        exp = sb.pop_front();
        if (obs_data[rd_idx % 256] !== exp) begin
          errors++;
          $display("FAIL lat_tx got=%h exp=%h", obs_data[rd_idx % 256], exp);
        end
      end
      rd_idx++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL lat_missing left=%0d exp=0", sb.size());
    end
  endtask

  task automatic test_overflow();
    int k;
    logic [7:0] exp;
    do_reset();
    auto_done = 1'b1;
    done_dly  = 3;
    for (int i = 1; i <= 8; i++) push(8'(i), 1'b1);
    @(negedge clock);
    checks++;
    if (level !== 4'd7 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_pre level=%0d ovf=%b exp 7/0", level, overflow);
    end
    push(8'hFF, 1'b0);
    wr_stop();
    @(negedge clock);
    checks++;
    if (full !== 1'b1 || level !== 4'd8 || overflow !== 1'b1 ||
        empty !== 1'b0) begin
      errors++;
      $display("FAIL ovf_full full=%b level=%0d ovf=%b empty=%b exp 1/8/1/0",
               full, level, overflow, empty);
    end
    @(posedge clock);
    #1 spi_ready = 1'b1;
    k = 0;
    while (n_start < rd_idx + 8 && k < 500) begin
      @(negedge clock);
      k++;
    end
    repeat (30) @(negedge clock);
    checks++;
    if (n_start - rd_idx != 8 || empty !== 1'b1 || level !== 4'd0) begin
      errors++;
      $display("FAIL ovf_count starts=%0d empty=%b level=%0d exp 8/1/0",
               n_start - rd_idx, empty, level);
    end
    while (rd_idx < n_start) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL ovf_extra got=%h exp none", obs_data[rd_idx % 256]);
      end else begin
        exp = sb.pop_front();
        if (obs_data[rd_idx % 256] !== exp) begin
          errors++;
          $display("FAIL ovf_tx got=%h exp=%h", obs_data[rd_idx % 256], exp);
        end
      end
      rd_idx++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL ovf_missing left=%0d exp=0", sb.size());
    end
  endtask

  task automatic test_stall();
    int k;
    int b;
    logic [7:0] exp;
    do_reset();
    auto_done = 1'b1;
    done_dly  = 5;
    for (int i = 0; i < 3; i++) push(8'h31 + 8'(i), 1'b1);
    wr_stop();
    repeat (10) @(negedge clock);
    checks++;
    if (n_start != rd_idx || level !== 4'd3 || busy !== 1'b0) begin
      errors++;
      $display("FAIL stall starts=%0d level=%0d busy=%b exp 0/3/0",
               n_start - rd_idx, level, busy);
    end
    @(posedge clock);
    #1 spi_ready = 1'b1;
    b = rd_idx;
    k = 0;
    while (n_start < b + 3 && k < 500) begin
      @(negedge clock);
      k++;
    end
    repeat (15) @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (n_start < b + 3 ||
          obs_t[(b + i + 1) % 256] - obs_t[(b + i) % 256] != 5 + GAP + 2) begin
        errors++;
        $display("FAIL stall_space idx=%0d got=%0d exp=%0d", i,
                 obs_t[(b + i + 1) % 256] - obs_t[(b + i) % 256], 5 + GAP + 2);
      end
    end
    while (rd_idx < n_start) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL stall_extra got=%h exp none", obs_data[rd_idx % 256]);
      end else begin
        exp = sb.pop_front();
        if (obs_data[rd_idx % 256] !== exp) begin
          errors++;
          $display("FAIL stall_tx got=%h exp=%h", obs_data[rd_idx % 256], exp);
        end
      end
      rd_idx++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL stall_missing left=%0d exp=0", sb.size());
    end
  endtask

  task automatic test_same_cycle();
    int k;
    logic [7:0] exp;
    do_reset();
    auto_done = 1'b1;
    done_dly  = 2;
    for (int i = 0; i < 4; i++) push(8'h40 + 8'(i), 1'b1);
    wr_stop();
    @(negedge clock);
    checks++;
    if (level !== 4'd4) begin
      errors++;
      $display("FAIL same_pre level=%0d exp=4", level);
    end
    @(posedge clock);
    #1;
    spi_ready = 1'b1;
    wr_en     = 1'b1;
    wr_data   = 8'h44;
    sb.push_back(8'h44);
    @(posedge clock);
    #1 wr_en = 1'b0;
    @(negedge clock);
    checks++;
    if (level !== 4'd4 || spi_start !== 1'b1) begin
      errors++;
      $display("FAIL same_cycle level=%0d start=%b exp 4/1",
               level, spi_start);
    end
    for (int i = 5; i < 8; i++) push(8'h40 + 8'(i), 1'b1);
    wr_stop();
    k = 0;
    while (n_start < rd_idx + 8 && k < 500) begin
      @(negedge clock);
      k++;
    end
    for (int i = 8; i < 12; i++) push(8'h40 + 8'(i), 1'b1);
    wr_stop();
    k = 0;
    while (n_start < rd_idx + 12 && k < 500) begin
      @(negedge clock);
      k++;
    end
    repeat (12) @(negedge clock);
    checks++;
    if (overflow !== 1'b0 || empty !== 1'b1 || n_start - rd_idx != 12) begin
      errors++;
      $display("FAIL wrap_state ovf=%b empty=%b starts=%0d exp 0/1/12",
               overflow, empty, n_start - rd_idx);
    end
    while (rd_idx < n_start) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL wrap_extra got=%h exp none", obs_data[rd_idx % 256]);
      end else begin
        exp = sb.pop_front();
        if (obs_data[rd_idx % 256] !== exp) begin
          errors++;
          $display("FAIL wrap_tx got=%h exp=%h", obs_data[rd_idx % 256], exp);
        end
      end
      rd_idx++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL wrap_missing left=%0d exp=0", sb.size());
    end
  endtask

  task automatic test_reset_mid();
    int k;
    logic [7:0] exp;
    do_reset();
    auto_done = 1'b0;
    for (int i = 0; i < 6; i++) push(8'h60 + 8'(i), 1'b1);
    wr_stop();
    @(posedge clock);
    #1 spi_ready = 1'b1;
    k = 0;
    while (n_start < rd_idx + 1 && k < 50) begin
      @(negedge clock);
      k++;
    end
    repeat (3) @(negedge clock);
    checks++;
    if (busy !== 1'b1 || level !== 4'd5 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL mid_pre busy=%b level=%0d tmo=%b exp 1/5/0",
               busy, level, timeout_err);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (level !== 4'd0 || empty !== 1'b1 || full !== 1'b0 ||
        busy !== 1'b0 || spi_start !== 1'b0 || spi_tx_data !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset level=%0d empty=%b full=%b busy=%b start=%b data=%h exp 0/1/0/0/0/00",
               level, empty, full, busy, spi_start, spi_tx_data);
    end
    checks++;
    if (n_start != rd_idx + 1 || obs_data[rd_idx % 256] !== 8'h60) begin
      errors++;
      $display("FAIL mid_first starts=%0d got=%h exp 1/60",
               n_start - rd_idx, obs_data[rd_idx % 256]);
    end
    rd_idx = n_start;
    sb.delete();
    @(posedge clock);
    #1 reset = 1'b0;
    repeat (20) @(negedge clock);
    #1;
    checks++;
    if (n_start != rd_idx || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_quiet starts=%0d busy=%b exp 0/0",
               n_start - rd_idx, busy);
    end
    auto_done = 1'b1;
    done_dly  = 2;
    push(8'h7E, 1'b1);
    wr_stop();
    k = 0;
    while (n_start < rd_idx + 1 && k < 50) begin
      @(negedge clock);
      k++;
    end
    repeat (15) @(negedge clock);
    while (rd_idx < n_start) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL mid_extra got=%h exp none", obs_data[rd_idx % 256]);
      end else begin
        exp = sb.pop_front();
        if (obs_data[rd_idx % 256] !== exp) begin
          errors++;
          $display("FAIL mid_tx got=%h exp=%h", obs_data[rd_idx % 256], exp);
        end
      end
      rd_idx++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL mid_missing left=%0d exp=0", sb.size());
    end
  endtask

`ifdef SPI_TX_FEEDER_TIMEOUT_EN
  task automatic test_timeout();
    int k;
    int b;
    logic [7:0] exp;
    do_reset();
    auto_done = 1'b0;
    spi_ready = 1'b1;
    push(8'h91, 1'b1);
    push(8'h92, 1'b1);
    wr_stop();
    b = rd_idx;
    k = 0;
    while (n_start < b + 1 && k < 50) begin
      @(negedge clock);
      k++;
    end
    #1;
    k = 0;
    while (!timeout_err && k < 100) begin
      @(negedge clock);
      k++;
    end
    checks++;
    if (timeout_err !== 1'b1 || cyc - obs_t[b % 256] != 17) begin
      errors++;
      $display("FAIL tmo_set tmo=%b dist=%0d exp 1/17",
               timeout_err, cyc - obs_t[b % 256]);
    end
    k = 0;
    while (n_start < b + 2 && k < 100) begin
      @(negedge clock);
      k++;
    end
    #1;
    checks++;
    if (n_start < b + 2 ||
        obs_t[(b + 1) % 256] - obs_t[b % 256] != 16 + GAP + 2) begin
      errors++;
      $display("FAIL tmo_next got=%0d exp=%0d",
               obs_t[(b + 1) % 256] - obs_t[b % 256], 16 + GAP + 2);
    end
    while (rd_idx < n_start) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL tmo_extra got=%h exp none", obs_data[rd_idx % 256]);
      end else begin
        exp = sb.pop_front();
        if (obs_data[rd_idx % 256] !== exp) begin
          errors++;
          $display("FAIL tmo_tx got=%h exp=%h", obs_data[rd_idx % 256], exp);
        end
      end
      rd_idx++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL tmo_missing left=%0d exp=0", sb.size());
    end
    do_reset();
  endtask
`endif

  initial begin
    test_reset();
    test_latency();
    test_overflow();
    test_stall();
    test_same_cycle();
    test_reset_mid();
`ifdef SPI_TX_FEEDER_TIMEOUT_EN
    test_timeout();
`endif
    checks++;
    if (dbl) begin
      errors++;
      $display("FAIL start_width got=multi-cycle exp=single");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
